// File: rtl/afifo_wr_ctrl_if.sv
// afifo_wr_ctrl_if
//   Write-request bus between the write-agent driver and the FIFO write
//   controller.
//   winc   : write request, one word per cycle while high
//   wdata  : word to be written
//   Modports: master = driver side, slave = controller side.
`timescale 1ns/1ps

interface afifo_wr_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (output winc, output wdata);
    modport slave  (input  winc, input  wdata);
endinterface

// File: rtl/afifo_wr_ctrl.sv
// afifo_wr_ctrl
//   Write-domain controller of the async FIFO. It gates driver writes into
//   the dual-port memory, keeps the binary/Gray write pointer, synchronises
//   the Gray read pointer into wclk and derives full, almost-full, a fill
//   level and a sticky overflow flag.
//   wclk, wrst_n  : write clock, async active-low reset
//   wr_bus        : driver request bus (winc, wdata), slave side
//   rptr_gray     : Gray read pointer from the read domain (asynchronous)
//   mem_wen/waddr/wdata : memory write port (combinational enable)
//   wptr_gray     : registered Gray write pointer to the read domain
//   wfull, walmost_full, wcount, woverflow : registered status
`timescale 1ns/1ps

module afifo_wr_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int AFULL_TH   = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    afifo_wr_ctrl_if.slave        wr_bus,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  woverflow
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AFULL_LEVEL = (AW+1)'((1 << AW) - AFULL_TH);

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] wq1_rptr;
    logic [AW:0] wq2_rptr;
    logic [AW:0] rbin_sync;
    logic [AW:0] fill_next;
    logic [AW:0] full_target;

    // Reset also masks the enable so a write held on the bus during reset
    // can never reach the memory.
    assign mem_wen   = wr_bus.winc & ~wfull & wrst_n;
    assign mem_waddr = wbin[AW-1:0];
    assign mem_wdata = wr_bus.wdata;

    assign wbin_next  = wbin + (AW+1)'(mem_wen);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at and
    // above it.
    always_comb begin
        rbin_sync = '0;
        for (int unsigned i = 0; i <= AW; i++) begin
            rbin_sync[i] = ^(wq2_rptr >> i);
        end
    end

    assign fill_next = wbin_next - rbin_sync;

    // Full when the write pointer is one lap ahead: top two Gray bits
    // inverted, remainder equal.
    assign full_target = {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq1_rptr <= '0;
            wq2_rptr <= '0;
        end else begin
            wq1_rptr <= rptr_gray;
            wq2_rptr <= wq1_rptr;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr_gray    <= wgray_next;
            wfull        <= (wgray_next == full_target);
            walmost_full <= (fill_next >= AFULL_LEVEL);
            wcount       <= fill_next;
            woverflow    <= woverflow | (wr_bus.winc & wfull);
        end
    end
endmodule

// File: tb/tb_afifo_wr_ctrl.sv
`timescale 1ns/1ps

module tb_afifo_wr_ctrl;
    localparam int DW = 32;
    localparam int AW = 8;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic [AW:0]   rptr_gray;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   wptr_gray;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wcount;
    logic          woverflow;

    int checks   = 0;
    int failures = 0;

    afifo_wr_ctrl_if #(.DATA_WIDTH(DW)) wr_bus ();

    afifo_wr_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AFULL_TH  (4)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .wr_bus      (wr_bus.slave),
        .rptr_gray   (rptr_gray),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wptr_gray   (wptr_gray),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wcount      (wcount),
        .woverflow   (woverflow)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [AW:0] gray(input int unsigned b);
        logic [AW:0] v;
        v = (AW+1)'(b);
        return v ^ (v >> 1);
    endfunction

    // Read pointer (binary) presented during wrap iteration j.
    function automatic int unsigned rptr_at(input int j);
        if (j < 3) return 256;
        return (253 + j) % 512;
    endfunction

    logic [AW:0] prev_gray;
    int unsigned exp_cnt;

    initial begin
        wrst_n        = 1'b0;
        wr_bus.winc   = 1'b1;
        wr_bus.wdata  = $urandom;
        rptr_gray     = '0;
        #23;
        check("rst_wfull",     32'(wfull),        0);
        check("rst_walmost",   32'(walmost_full), 0);
        check("rst_woverflow", 32'(woverflow),    0);
        check("rst_wcount",    32'(wcount),       0);
        check("rst_wptr",      32'(wptr_gray),    0);

        @(negedge wclk);
        wrst_n      = 1'b1;
        wr_bus.winc = 1'b0;

        // Fill 256 words with rptr at 0.
        for (int i = 0; i < 256; i++) begin
            @(negedge wclk);
            wr_bus.winc  = 1'b1;
            wr_bus.wdata = $urandom;
            #1;
            check("fill_wen",   32'(mem_wen),   1);
            check("fill_waddr", 32'(mem_waddr), 32'(i));
            check("fill_wdata", mem_wdata,      wr_bus.wdata);
            @(posedge wclk);
            #1;
            check("fill_wcount",  32'(wcount),       32'(i + 1));
            check("fill_walmost", 32'(walmost_full), 32'(i + 1 >= 252));
            check("fill_wfull",   32'(wfull),        32'(i + 1 == 256));
            check("fill_wptr",    32'(wptr_gray),    32'(gray(i + 1)));
        end

        // Writes while full are rejected and latch overflow.
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            #1;
            check("ovf_wen", 32'(mem_wen), 0);
            @(posedge wclk);
            #1;
            check("ovf_flag",   32'(woverflow), 1);
            check("ovf_wptr",   32'(wptr_gray), 32'h180);
            check("ovf_wcount", 32'(wcount),    256);
            check("ovf_wfull",  32'(wfull),     1);
        end
        @(negedge wclk);
        wr_bus.winc = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        check("ovf_sticky", 32'(woverflow), 1);

        // One read: full clears on the third edge.
        @(negedge wclk);
        rptr_gray = gray(1);
        for (int e = 1; e <= 3; e++) begin
            @(posedge wclk);
            #1;
            check("drain_wfull", 32'(wfull), 32'(e < 3));
        end
        check("drain_wcount",  32'(wcount),       255);
        check("drain_walmost", 32'(walmost_full), 1);

        // Empty the FIFO from the write side's view.
        @(negedge wclk);
        rptr_gray = gray(256);
        repeat (3) @(posedge wclk);
        #1;
        check("empty_wcount",   32'(wcount),       0);
        check("empty_walmost",  32'(walmost_full), 0);
        check("empty_wfull",    32'(wfull),        0);
        check("empty_overflow", 32'(woverflow),    1);

        // 600 writes with the read pointer trailing by 3, across the wrap.
        for (int k = 0; k < 600; k++) begin
            @(negedge wclk);
            wr_bus.winc = 1'b1;
            rptr_gray   = gray(rptr_at(k));
            #1;
            check("wrap_waddr", 32'(mem_waddr), 32'((256 + k) % 256));
            prev_gray = wptr_gray;
            @(posedge wclk);
            #1;
            exp_cnt = (257 + k - rptr_at(k - 2)) % 512;
            check("wrap_wptr",   32'(wptr_gray),                 32'(gray(257 + k)));
            check("wrap_1bit",   32'($countones(prev_gray ^ wptr_gray)), 1);
            check("wrap_wfull",  32'(wfull),                     0);
            check("wrap_wcount", 32'(wcount),                    exp_cnt);
        end

        // Async reset in the middle of a burst.
        repeat (3) @(negedge wclk);
        @(posedge wclk);
        #3;
        wrst_n    = 1'b0;
        rptr_gray = '0;
        #1;
        check("mrst_wptr",     32'(wptr_gray),    0);
        check("mrst_wcount",   32'(wcount),       0);
        check("mrst_wfull",    32'(wfull),        0);
        check("mrst_walmost",  32'(walmost_full), 0);
        check("mrst_overflow", 32'(woverflow),    0);
        check("mrst_waddr",    32'(mem_waddr),    0);
        @(negedge wclk);
        wrst_n = 1'b1;
        #1;
        check("mrst_first_wen",   32'(mem_wen),   1);
        check("mrst_first_waddr", 32'(mem_waddr), 0);
        @(posedge wclk);
        #1;
        check("mrst_first_wptr",   32'(wptr_gray), 1);
        check("mrst_first_wcount", 32'(wcount),    1);
        check("mrst_first_ovf",    32'(woverflow), 0);

        @(negedge wclk);
        wr_bus.winc = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/afifo_wr_ctrl.md
# afifo_wr_ctrl

Synthesizable write-domain controller of the async FIFO DUT. It sits directly downstream of the write-agent driver and consumes its `winc`/`wdata` bus. It gates writes into the dual-port memory and maintains the binary/Gray write pointer. From the read pointer, synchronized into `wclk`, it generates `wfull`, `walmost_full`, a fill-level estimate and a sticky overflow flag.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of a FIFO word.
- `ADDR_WIDTH`, 8: memory address width; DEPTH = 2**ADDR_WIDTH.
- `AFULL_TH`, 4: `walmost_full` asserts when free slots <= `AFULL_TH`; legal range 1..DEPTH-1.

Ports:
- `wclk`  in  1  write-domain clock; all state is on its rising edge.
- `wrst_n`  in  1  asynchronous, active-low reset.
- `winc`  in  1  write request from the driver bus.
- `wdata`  in  DATA_WIDTH  write data from the driver bus.
- `rptr_gray`  in  ADDR_WIDTH+1  read pointer, Gray coded, asynchronous to `wclk`.
- `mem_wen`  out  1  memory write enable (combinational).
- `mem_waddr`  out  ADDR_WIDTH  memory write address.
- `mem_wdata`  out  DATA_WIDTH  memory write data; equals `wdata`.
- `wptr_gray`  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- `wfull`  out  1  FIFO full, registered.
- `walmost_full`  out  1  almost-full, registered.
- `wcount`  out  ADDR_WIDTH+1  fill level as seen from the write domain (0..DEPTH), registered.
- `woverflow`  out  1  sticky: a write was attempted while full.

## Operation
- State:
  - `wbin`: binary write pointer, ADDR_WIDTH+1 bits.
  - `wptr_gray`.
  - `wq1_rptr` and `wq2_rptr`: 2-flop synchronizer of `rptr_gray`.
  - Output registers.
- Write acceptance is combinational: `mem_wen = winc & ~wfull`.
  - `mem_waddr = wbin[ADDR_WIDTH-1:0]`.
  - `mem_wdata = wdata`.
- Next-pointer values:
  - `wbin_next = wbin + mem_wen`, modulo 2**(ADDR_WIDTH+1); it wraps naturally.
  - `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- Full flag: `wfull <= (wgray_next == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]})`, where AW = ADDR_WIDTH.
- Fill level:
  - `rbin_sync` = Gray-to-binary conversion of `wq2_rptr`.
  - `wcount <= wbin_next - rbin_sync`, unsigned, ADDR_WIDTH+1 bits.
- Almost-full: `walmost_full <= (wbin_next - rbin_sync) >= DEPTH - AFULL_TH`. It is therefore 1 whenever `wfull` is 1.
- Overflow:
  - `woverflow <= woverflow | (winc & wfull)`.
  - It clears only on reset.
  - A rejected write changes neither the pointer nor the memory.
- The full and almost-full flags are conservative: the synchronizer lags, so a flag can remain set after reads. It must never be clear while the FIFO is truly full.

## Timing
- Reset (async assert, release synchronous to `wclk` at system level): every register goes to 0.
  - `wbin`, `wptr_gray`, `wq1_rptr`, `wq2_rptr`, `wfull`, `walmost_full`, `wcount` and `woverflow` are all 0.
  - `mem_wen` follows `winc & ~wfull`, so it is 0 when `winc` is 0.
- Write latency:
  - The write lands in memory on the same edge on which `winc` is sampled high.
  - `wptr_gray`, `wcount` and the flags update on that same edge.
- Read-side visibility: a change on `rptr_gray` before edge t appears in `wq2_rptr` after edge t+1. `wfull`, `walmost_full` and `wcount` reflect it after edge t+2, i.e. a 3-edge worst case.
- Simultaneous write on the last free slot: `wfull` rises on the same edge that accepts the write. A `winc` held high on the next cycle is rejected and sets `woverflow` on that edge.
- Back-to-back writes: one write is accepted per cycle while `wfull` is 0.
- Wrap-around: after 2**(ADDR_WIDTH+1) accepted writes, `wbin` and `wptr_gray` return to 0.
  - The MSB toggle distinguishes full from empty.
  - `wptr_gray` changes by exactly 1 bit per accepted write.
- Reset mid-operation: all state clears asynchronously. Any in-flight `winc` is not accepted while `wrst_n` is 0.

## Test plan
- Reset check: assert `wrst_n`=0 with `winc`=1 and random `wdata` -> `wfull`=`walmost_full`=`woverflow`=0, `wcount`=0, `wptr_gray`=0.
- Fill: `rptr_gray`=0, 256 consecutive writes (ADDR_WIDTH=8) -> `mem_waddr` runs 0..255; `walmost_full` rises on the edge making `wcount`=252; `wfull`=1 and `wcount`=256 on the 256th edge.
- Overflow: the FIFO is full and `winc`=1 for 3 cycles -> `mem_wen`=0, `wptr_gray` stays at 9'h180, `woverflow`=1 after the first edge and stays 1 until reset.
- Drain visibility: the FIFO is full and `rptr_gray` changes 0 -> 1 -> `wfull` falls on the third `wclk` edge after the change, with `wcount`=255.
- Wrap: 600 writes interleaved with read-pointer advances keeping occupancy below 8 -> `wbin` wraps past 511 to 0; every `wptr_gray` transition is a single-bit change; `wfull` never asserts.
- Mid-op reset: pulse `wrst_n` low asynchronously (not aligned to `wclk`) in the middle of a burst of writes -> all outputs are 0 immediately; after release, the first write goes to `mem_waddr`=0.
